// File: rtl/fp_pkg.sv
// Shared constants and FSM state type for the single-precision divider.
package fp_pkg;

  localparam int BIAS      = 127;
  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int DIV_ITERS = 25;
  localparam int CNT_W     = 5;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } fsm_state_e;

  // A zero exponent field means zero; denormals are flushed.
  function automatic logic exp_is_zero(input logic [EXP_W-1:0] e);
    return (e == '0);
  endfunction

  // All-ones exponent covers both Inf and NaN operands.
  function automatic logic exp_is_max(input logic [EXP_W-1:0] e);
    return (e == '1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: compare, conditionally subtract, shift left.
module div_step
  import fp_pkg::*;
(
  input  logic [MAN_W+1:0] r,
  input  logic [MAN_W:0]   mb,
  output logic             q,
  output logic [MAN_W+1:0] r_next
);

  logic [MAN_W+1:0] diff;

  // Quotient bit and next partial remainder; the shifted-out MSB is always zero.
  always_comb begin
    q      = (r >= {1'b0, mb});
    diff   = q ? (r - {1'b0, mb}) : r;
    r_next = {diff[MAN_W:0], 1'b0};
  end

endmodule

// File: rtl/fp_divider.sv
// Single-precision floating-point divider, fixed 27-cycle latency.
//
// state | meaning
// IDLE  | waiting for start; operands captured when start is seen
// DIV   | one restoring quotient bit per cycle, 25 cycles
// NORM  | pick mantissa window from the quotient and form the exponent
// DONE  | apply special cases/range checks; result and done register on exit
module fp_divider
  import fp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow,
  output logic            exception
);

  fsm_state_e        state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [MAN_W+1:0]  r_q, r_d;
  logic [MAN_W+1:0]  quo_q, quo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MAN_W-1:0]  man_q, man_d;
  logic signed [9:0] exp_q, exp_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              exc_q, exc_d;
  logic              done_q, done_d;

  logic              step_bit;
  logic [MAN_W+1:0]  step_r;

  logic              sign;
  logic [EXP_W-1:0]  ea, eb;

  assign ea   = a_q[MAN_W+EXP_W-1:MAN_W];
  assign eb   = b_q[MAN_W+EXP_W-1:MAN_W];
  assign sign = a_q[XLEN-1] ^ b_q[XLEN-1];

  div_step u_div_step (
    .r      (r_q),
    .mb     ({1'b1, b_q[MAN_W-1:0]}),
    .q      (step_bit),
    .r_next (step_r)
  );

  // Next-state, datapath and output logic for all four states.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    man_d    = man_q;
    exp_d    = exp_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    exc_d    = exc_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DIV;
          a_d     = A;
          b_d     = B;
          r_d     = {2'b01, A[MAN_W-1:0]};
          quo_d   = '0;
          cnt_d   = '0;
        end
      end

      DIV: begin
        r_d   = step_r;
        quo_d = {quo_q[MAN_W:0], step_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
          state_d = NORM;
        end
      end

      NORM: begin
        // A quotient below 1.0 costs one exponent step and uses the lower window.
        man_d   = quo_q[MAN_W+1] ? quo_q[MAN_W:1] : quo_q[MAN_W-1:0];
        exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb})
                + $signed(10'(BIAS))
                - (quo_q[MAN_W+1] ? 10'sd0 : 10'sd1);
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        exc_d   = 1'b0;
        if (exp_is_max(ea) || exp_is_max(eb) ||
            (exp_is_zero(ea) && exp_is_zero(eb))) begin
          result_d = QNAN;
          exc_d    = 1'b1;
        end else if (exp_is_zero(eb)) begin
          result_d = {sign, POS_INF[XLEN-2:0]};
          exc_d    = 1'b1;
        end else if (exp_is_zero(ea)) begin
          result_d = {sign, {(XLEN-1){1'b0}}};
        end else if (exp_q > 10'sd254) begin
          result_d = {sign, POS_INF[XLEN-2:0]};
          ovf_d    = 1'b1;
        end else if (exp_q < 10'sd1) begin
          result_d = {sign, {(XLEN-1){1'b0}}};
          unf_d    = 1'b1;
        end else begin
          result_d = {sign, exp_q[EXP_W-1:0], man_q};
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any division in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      man_q    <= '0;
      exp_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      exc_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      man_q    <= man_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      exc_q    <= exc_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q == DIV) || (state_q == NORM);
  assign done      = done_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign exception = exc_q;

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed corner cases plus random operands
// compared against an integer-arithmetic reference of IEEE single division.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] result;
  logic        overflow, underflow, exception;

  int checks = 0;
  int errors = 0;
  time t_done = 0;

  fp_divider #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .exception (exception)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Quotient of the 24-bit significands scaled by 2^24, truncated.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [2:0] flags);
    int ea, eb, ex;
    logic s;
    longint ma, mb, qq;
    logic [22:0] man;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s = a[31] ^ b[31];
    flags = 3'b000;
    r = 32'h0;
    if (ea == 255 || eb == 255 || (ea == 0 && eb == 0)) begin
      r = 32'h7FC00000; flags = 3'b001;
    end else if (eb == 0) begin
      r = {s, 8'hFF, 23'h0}; flags = 3'b001;
    end else if (ea == 0) begin
      r = {s, 31'h0};
    end else begin
      ma = longint'(a[22:0]) + 64'd8388608;
      mb = longint'(b[22:0]) + 64'd8388608;
      qq = (ma * 64'd16777216) / mb;
      if (qq >= 64'd16777216) begin
        man = 23'(qq / 2);
        ex  = ea - eb + 127;
      end else begin
        man = 23'(qq);
        ex  = ea - eb + 126;
      end
      if (ex > 254) begin
        r = {s, 8'hFF, 23'h0}; flags = 3'b100;
      end else if (ex < 1) begin
        r = {s, 31'h0}; flags = 3'b010;
      end else begin
        r = {s, 8'(ex), man};
      end
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) e = 8'h00;
    else if (k == 1) e = 8'hFF;
    else e = 8'($urandom_range(1, 254));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Issue one operation from mid-cycle; optionally poke start during DIV and DONE.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic [2:0] exp_f, input bit poke);
    int n;
    bit seen;
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom; B = $urandom;
    chk({tag, " busy"}, {31'b0, busy}, 32'd1);
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      if (poke && (n == 3 || n == 26)) start = 1'b1;
      else start = 1'b0;
      @(posedge clk); #1;
      n++;
      if (done) seen = 1;
    end
    start = 1'b0;
    t_done = $time;
    chk({tag, " latency"}, 32'(n), 32'd27);
    chk({tag, " result"}, result, exp_r);
    chk({tag, " flags"}, {29'b0, overflow, underflow, exception}, {29'b0, exp_f});
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen_done;
    seen_done = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    chk({tag, " no done"}, 32'(seen_done), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, er, er2, held;
    logic [2:0] ef, ef2;
    time t1;

    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {26'b0, busy, done, overflow, underflow, exception, 1'b0}, 32'd0);
    chk("reset result", result, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("6/2",      32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 0);
    run_op("1/3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000, 0);
    run_op("1/0",      32'h3F800000, 32'h00000000, 32'h7F800000, 3'b001, 0);
    run_op("nan/1",    32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b001, 0);
    run_op("0/0",      32'h00000000, 32'h80000000, 32'h7FC00000, 3'b001, 0);
    run_op("-0/1",     32'h80000000, 32'h3F800000, 32'h80000000, 3'b000, 0);
    run_op("inf/0",    32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001, 0);
    run_op("-1/0",     32'hBF800000, 32'h00000000, 32'hFF800000, 3'b001, 0);
    run_op("ovf",      32'h7F000000, 32'h00800000, 32'h7F800000, 3'b100, 0);
    run_op("unf",      32'h00800000, 32'h7F000000, 32'h00000000, 3'b010, 0);
    run_op("-6/2",     32'hC0C00000, 32'h40000000, 32'hC0400000, 3'b000, 0);

    held = result;
    expect_quiet("hold", 5);
    chk("hold result", result, held);

    run_op("poke", 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 1);
    expect_quiet("poke", 35);

    A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst outputs", {27'b0, busy, done, overflow, underflow, exception}, 32'd0);
    chk("midrst result", result, 32'd0);
    expect_quiet("midrst", 35);

    A = 32'h40C00000; B = 32'h40000000; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst+start busy", {31'b0, busy}, 32'd0);
    expect_quiet("rst+start", 32);

    ra = rand_fp(); rb = rand_fp();
    ref_div(ra, rb, er, ef);
    run_op("b2b first", ra, rb, er, ef, 0);
    t1 = t_done;
    ra = rand_fp(); rb = rand_fp();
    ref_div(ra, rb, er2, ef2);
    run_op("b2b second", ra, rb, er2, ef2, 0);
    chk("b2b spacing", 32'((t_done - t1) / 10), 32'd28);

    for (int i = 0; i < 24; i++) begin
      ra = rand_fp(); rb = rand_fp();
      ref_div(ra, rb, er, ef);
      run_op($sformatf("rand%0d %h/%h", i, ra, rb), ra, rb, er, ef, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fp_divider.md
FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 (IEEE-754 single) supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 A  input  XLEN  dividend, IEEE-754 single.
REQ-006 B  input  XLEN  divisor, IEEE-754 single.
REQ-007 busy  output  1  high while a division is in progress (states DIV, NORM).
REQ-008 done  output  1  one-cycle pulse; result/flags valid.
REQ-009 result  output  XLEN  quotient A/B, registered.
REQ-010 overflow  output  1  exponent overflow on last result.
REQ-011 underflow  output  1  exponent underflow on last result.
REQ-012 exception  output  1  divide-by-zero or NaN/Inf operand on last result.

Function
REQ-013 FSM states IDLE, DIV, NORM, DONE; IDLE->DIV on start; DIV->NORM after 25 iterations; NORM->DONE; DONE->IDLE unconditionally.
REQ-014 On start in IDLE, A and B SHALL be captured; later changes on A/B SHALL not affect the operation.
REQ-015 start while busy or in DONE SHALL be ignored (not queued).
REQ-016 Mantissas MA={1,A[22:0]}, MB={1,B[22:0]}; restoring division, one quotient bit per cycle, 25 cycles: R starts as MA; each step q_i=(R>=MB), R=(q_i ? R-MB : R)<<1; R held in 25 bits.
REQ-017 25-bit quotient Q: if Q[24]=1 mantissa=Q[23:1], else mantissa=Q[22:0]; truncation, no rounding.
REQ-018 Exponent computed in 10-bit signed arithmetic: E=EA-EB+127-(Q[24]?0:1); sign = A[31]^B[31].
REQ-019 E>254 -> result {sign,8'hFF,23'h0}, overflow=1; E<1 -> result {sign,31'h0}, underflow=1.
REQ-020 Special cases (exponent field 0 treated as zero; denormals flushed): A or B exponent 8'hFF, or A and B both zero -> result 32'h7FC00000, exception=1; B zero, A nonzero -> {sign,8'hFF,23'h0}, exception=1; A zero, B nonzero -> {sign,31'h0}, no flags.
REQ-021 Special-case priority: NaN/Inf > divide-by-zero > zero dividend > overflow/underflow.
REQ-022 Latency fixed: done SHALL assert exactly 27 rising edges after the edge sampling start, for all operands including special cases.
REQ-023 result and flags SHALL update in the cycle done asserts and hold until the next done or reset.
REQ-024 Back-to-back: start asserted in the cycle after done (FSM in IDLE) SHALL be accepted.

Reset
REQ-025 rst SHALL force IDLE and clear result, overflow, underflow, exception, busy, done to 0 on the next edge, including mid-operation; the aborted division SHALL never produce done.
REQ-026 rst has priority over start in the same cycle.

Structure
REQ-027 Package fp_pkg SHALL hold BIAS=127, EXP_W=8, MAN_W=23, QNAN=32'h7FC00000, POS_INF=32'h7F800000, DIV_ITERS=25, and the FSM state enum.
REQ-028 One sub-module div_step (combinational: R, MB in -> q bit, next R) SHALL be instantiated once, reused each DIV cycle; iteration counter is 5 bits.

Verification
REQ-029 A=40C00000 (6.0), B=40000000 (2.0) -> done after 27 cycles, result 40400000, flags 0.
REQ-030 A=3F800000 (1.0), B=40400000 (3.0) -> result 3EAAAAAA (truncated), flags 0.
REQ-031 A=3F800000, B=00000000 -> result 7F800000, exception=1; A=7FC00000, B=3F800000 -> 7FC00000, exception=1.
REQ-032 A=7F000000, B=00800000 -> result 7F800000, overflow=1; A=00800000, B=7F000000 -> result 00000000, underflow=1.
REQ-033 Start, rst at cycle 10 -> all outputs 0, no done pulse; start re-applied after DIV begins -> ignored, single done.
REQ-034 Two back-to-back operations (second start the cycle after done) -> two done pulses 28 cycles apart, both results correct.
